// File: rtl/vend_dispense_ctrl.sv
// Dispense back end: queues product/change requests, serialises motor and
// hopper operations, confirms each via its sensor and faults on timeout.
module vend_dispense_ctrl #(
   parameter int unsigned PULSE_CYCLES = 4,
   parameter int unsigned TIMEOUT      = 1000,
   parameter int unsigned CW           = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vend,
   input  logic [1:0] change,
   input  logic       product_sensed,
   input  logic       coin5_sensed,
   input  logic       coin10_sensed,
   input  logic       hopper10_empty,
   input  logic       clr_fault,
   output logic       motor_on,
   output logic       eject5,
   output logic       eject10,
   output logic       busy,
   output logic       fault,
   output logic       overflow
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] P_LAST = TW'(PULSE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, MOTOR, EJ5, WAIT5, EJ10, WAIT10, FAULT
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   prod_cnt, c5_cnt, c10_cnt;
   logic [TW-1:0]   timer;
   logic            conf;
   logic            split, split_done;

   logic            timer_clr;
   logic            prod_dec, c5_dec, c10_dec;
   logic            split_set, split_done_set, split_clr;
   logic            c5_inc, c10_inc;

   assign c5_inc  = (change == 2'b01);
   assign c10_inc = (change == 2'b10);

   function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                              input logic inc,
                                              input logic dec);
      if (inc && !dec)
         return (c == '1) ? c : c + 1'b1;
      if (dec && !inc)
         return c - 1'b1;
      return c;
   endfunction

   always_comb begin
      state_nx       = state;
      timer_clr      = 1'b0;
      prod_dec       = 1'b0;
      c5_dec         = 1'b0;
      c10_dec        = 1'b0;
      split_set      = 1'b0;
      split_done_set = 1'b0;
      split_clr      = 1'b0;
      case (state)
         IDLE: begin
            if (prod_cnt != '0) begin
               state_nx  = MOTOR;
               timer_clr = 1'b1;
            end else if (c10_cnt != '0) begin
               timer_clr = 1'b1;
               // a split interrupted by a fault keeps paying in 5$ coins
               if (split || hopper10_empty) begin
                  state_nx  = EJ5;
                  split_set = 1'b1;
               end else begin
                  state_nx = EJ10;
               end
            end else if (c5_cnt != '0) begin
               state_nx  = EJ5;
               timer_clr = 1'b1;
            end
         end
         MOTOR: begin
            if (product_sensed) begin
               prod_dec = 1'b1;
               state_nx = IDLE;
            end else if (timer == T_LAST) begin
               state_nx = FAULT;
            end
         end
         EJ5: begin
            if (timer == P_LAST)
               state_nx = WAIT5;
         end
         WAIT5: begin
            if (conf || coin5_sensed) begin
               if (!split) begin
                  c5_dec   = 1'b1;
                  state_nx = IDLE;
               end else if (split_done) begin
                  c10_dec   = 1'b1;
                  split_clr = 1'b1;
                  state_nx  = IDLE;
               end else begin
                  split_done_set = 1'b1;
                  timer_clr      = 1'b1;
                  state_nx       = EJ5;
               end
            end else if (timer == T_LAST) begin
               state_nx = FAULT;
            end
         end
         EJ10: begin
            if (timer == P_LAST)
               state_nx = WAIT10;
         end
         WAIT10: begin
            if (conf || coin10_sensed) begin
               c10_dec  = 1'b1;
               state_nx = IDLE;
            end else if (timer == T_LAST) begin
               state_nx = FAULT;
            end
         end
         FAULT: begin
            if (clr_fault)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Timer runs across an EJ/WAIT pair, so the timeout covers the strobe too
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer <= '0;
         conf  <= 1'b0;
      end else begin
         if (timer_clr)
            timer <= '0;
         else if (state inside {MOTOR, EJ5, WAIT5, EJ10, WAIT10})
            timer <= timer + 1'b1;

         if (timer_clr)
            conf <= 1'b0;
         else if ((state == EJ5 && coin5_sensed) || (state == EJ10 && coin10_sensed))
            conf <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         split      <= 1'b0;
         split_done <= 1'b0;
      end else if (split_clr) begin
         split      <= 1'b0;
         split_done <= 1'b0;
      end else begin
         if (split_set)
            split <= 1'b1;
         if (split_done_set)
            split_done <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_cnt <= '0;
         c5_cnt   <= '0;
         c10_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         prod_cnt <= cnt_next(prod_cnt, vend, prod_dec);
         c5_cnt   <= cnt_next(c5_cnt, c5_inc, c5_dec);
         c10_cnt  <= cnt_next(c10_cnt, c10_inc, c10_dec);
         if ((vend && !prod_dec && prod_cnt == '1) ||
             (c5_inc && !c5_dec && c5_cnt == '1) ||
             (c10_inc && !c10_dec && c10_cnt == '1))
            overflow <= 1'b1;
      end
   end

   assign motor_on = (state == MOTOR);
   assign eject5   = (state == EJ5);
   assign eject10  = (state == EJ10);
   assign fault    = (state == FAULT);
   assign busy     = (state != IDLE) || (prod_cnt != '0) || (c5_cnt != '0) || (c10_cnt != '0);

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: directed vector table, hand-written fault,
// saturation and reset sequences, and a randomized run against a request model.
`timescale 1ns/1ps
module tb_vend_dispense_ctrl;

   localparam int unsigned PC  = 4;
   localparam int unsigned TO  = 1000;
   localparam int unsigned CW  = 3;
   localparam int unsigned SAT = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vend = 1'b0;
   logic [1:0] change = 2'b00;
   logic       product_sensed = 1'b0;
   logic       coin5_sensed = 1'b0;
   logic       coin10_sensed = 1'b0;
   logic       hopper10_empty = 1'b0;
   logic       clr_fault = 1'b0;
   logic       motor_on, eject5, eject10, busy, fault, overflow;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   vend_dispense_ctrl #(.PULSE_CYCLES(PC), .TIMEOUT(TO), .CW(CW)) dut (
      .clk(clk), .rst(rst), .vend(vend), .change(change),
      .product_sensed(product_sensed), .coin5_sensed(coin5_sensed),
      .coin10_sensed(coin10_sensed), .hopper10_empty(hopper10_empty),
      .clr_fault(clr_fault), .motor_on(motor_on), .eject5(eject5),
      .eject10(eject10), .busy(busy), .fault(fault), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic checkb(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checkn(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset(input logic empty);
      rst = 1'b1;
      {vend, change, product_sensed, coin5_sensed, coin10_sensed, clr_fault} = '0;
      hopper10_empty = empty;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // in  = {vend, change[1:0], product_sensed, coin5_sensed, coin10_sensed, hopper10_empty, clr_fault}
   // exp = {motor_on, eject5, eject10, busy, fault, overflow}
   typedef struct packed {
      logic [7:0] in;
      logic [5:0] exp;
   } vec_t;

   localparam int unsigned NV = 36;
   vec_t tbl [NV];

   task automatic put(input int unsigned i, input logic [7:0] in, input logic [5:0] exp);
      tbl[i].in  = in;
      tbl[i].exp = exp;
   endtask

   // Randomized run; empty_mode holds the 10$ hopper empty and requests only
   // products and 10$ change, so every 10$ refund is paid as two 5$ coins.
   task automatic random_phase(input bit empty_mode, input int unsigned n_gen);
      int unsigned mp = 0, m5 = 0, m10 = 0;
      int unsigned acc_p = 0, acc5 = 0, acc10 = 0;
      int unsigned motor_ops = 0, e5_pulses = 0, e10_pulses = 0;
      bit movf = 0, split_half = 0;
      bit prev_m = 0, prev_e5 = 0, prev_e10 = 0;
      int unsigned m_age = 0, m_d = 0, e_age = 0, e_d = 0, len = 0;
      bit m_fired = 0, e_active = 0, e_fired = 0, e_latched = 0, e_is10 = 0;
      bit drained = 0;
      int unsigned cyc = 0;
      bit dp, d5, d10, confirm, ej_high, i5, i10, gen;
      int unsigned r;

      do_reset(empty_mode);
      while (cyc < n_gen + 3000) begin
         @(negedge clk);
         gen = (cyc < n_gen);
         cyc++;
         if (!gen && (mp + m5 + m10) == 0 && !busy) begin
            drained = 1;
            break;
         end
         checkb("random busy", busy, (mp + m5 + m10) != 0);
         checkb("random overflow", overflow, movf);
         checkb("random fault", fault, 1'b0);
         checkb("single actuator", $onehot0({motor_on, eject5, eject10}), 1'b1);

         dp = 0; d5 = 0; d10 = 0; confirm = 0;
         product_sensed = 0; coin5_sensed = 0; coin10_sensed = 0;
         ej_high = eject5 || eject10;

         if (motor_on && !prev_m) begin
            m_age = 0; m_d = $urandom_range(0, 6); m_fired = 0;
         end
         if (motor_on && !m_fired && m_age == m_d) begin
            product_sensed = 1; m_fired = 1; dp = 1; motor_ops++;
         end
         m_age++;

         if ((eject5 && !prev_e5) || (eject10 && !prev_e10)) begin
            e_age = 0; e_d = $urandom_range(0, 8); e_fired = 0; e_latched = 0;
            e_active = 1; e_is10 = eject10; len = 0;
            if (eject10) e10_pulses++; else e5_pulses++;
         end
         if (ej_high) len++;
         if ((prev_e5 && !eject5) || (prev_e10 && !eject10))
            checkn("eject width", len, PC);

         if (e_active) begin
            if (!e_fired && e_age == e_d) begin
               if (e_is10) coin10_sensed = 1; else coin5_sensed = 1;
               e_fired = 1;
               if (ej_high) e_latched = 1; else confirm = 1;
            end else if (e_latched && !ej_high) begin
               confirm = 1;
            end
            e_age++;
         end
         if (confirm) begin
            e_active = 0; e_latched = 0;
            if (e_is10) d10 = 1;
            else if (empty_mode) begin
               if (split_half) d10 = 1;
               split_half = !split_half;
            end else d5 = 1;
         end

         r = $urandom_range(0, 15);
         vend = gen && ($urandom_range(0, 7) == 0);
         if (!gen || r > 3) change = 2'b00;
         else if (empty_mode) change = (r < 2) ? 2'b10 : 2'b00;
         else change = r[1:0];
         i5  = (change == 2'b01);
         i10 = (change == 2'b10);

         if ((dp && mp == 0) || (d5 && m5 == 0) || (d10 && m10 == 0))
            checkb("completion with nothing pending", 1'b1, 1'b0);
         if ((vend && !dp && mp == SAT) || (i5 && !d5 && m5 == SAT) || (i10 && !d10 && m10 == SAT))
            movf = 1;
         if (vend && !(mp == SAT && !dp)) acc_p++;
         if (i5 && !(m5 == SAT && !d5)) acc5++;
         if (i10 && !(m10 == SAT && !d10)) acc10++;
         mp  = mp + int'(vend) - int'(dp);
         m5  = m5 + int'(i5) - int'(d5);
         m10 = m10 + int'(i10) - int'(d10);
         if (mp > SAT) mp = SAT;
         if (m5 > SAT) m5 = SAT;
         if (m10 > SAT) m10 = SAT;

         prev_m = motor_on; prev_e5 = eject5; prev_e10 = eject10;
      end
      {vend, change, product_sensed, coin5_sensed, coin10_sensed} = '0;
      checkb("random drain", drained, 1'b1);
      checkn("random motor ops", motor_ops, acc_p);
      if (empty_mode) begin
         checkn("split eject5 pulses", e5_pulses, 2 * acc10);
         checkn("split eject10 pulses", e10_pulses, 0);
      end else begin
         checkn("random eject5 pulses", e5_pulses, acc5);
         checkn("random eject10 pulses", e10_pulses, acc10);
      end
   endtask

   initial begin
      bit          found;
      int unsigned ops, cyc;

      for (int unsigned i = 0; i < NV; i++) put(i, 8'b0, 6'b0);
      put(0, 8'b1010_0000, 6'b000000);
      put(1, 8'b0000_0000, 6'b000100);
      for (int unsigned i = 2; i <= 5; i++) put(i, 8'b0000_0000, 6'b100100);
      put(6, 8'b0001_0000, 6'b100100);
      put(7, 8'b0000_0000, 6'b000100);
      for (int unsigned i = 8; i <= 11; i++) put(i, 8'b0000_0000, 6'b010100);
      put(12, 8'b0000_1000, 6'b000100);
      put(13, 8'b0100_0000, 6'b000000);
      put(14, 8'b0000_0000, 6'b000100);
      for (int unsigned i = 15; i <= 18; i++) put(i, 8'b0000_0000, 6'b001100);
      put(16, 8'b0000_0100, 6'b001100);
      put(19, 8'b0000_0000, 6'b000100);
      put(20, 8'b0100_0010, 6'b000000);
      put(21, 8'b0000_0010, 6'b000100);
      for (int unsigned i = 22; i <= 25; i++) put(i, 8'b0000_0010, 6'b010100);
      put(26, 8'b0000_0010, 6'b000100);
      put(27, 8'b0000_1010, 6'b000100);
      for (int unsigned i = 28; i <= 31; i++) put(i, 8'b0000_0010, 6'b010100);
      put(32, 8'b0000_1010, 6'b000100);
      put(33, 8'b0110_0000, 6'b000000);

      do_reset(1'b0);
      checkn("reset outputs", {motor_on, eject5, eject10, busy, fault, overflow}, 0);
      for (int unsigned i = 0; i < NV; i++) begin
         @(negedge clk);
         checkn($sformatf("table row %0d outputs", i),
                {motor_on, eject5, eject10, busy, fault, overflow}, tbl[i].exp);
         {vend, change, product_sensed, coin5_sensed, coin10_sensed, hopper10_empty, clr_fault} = tbl[i].in;
      end

      // Motor timeout, requests counted while faulted, then retry after clear
      do_reset(1'b0);
      @(negedge clk) vend = 1;
      @(negedge clk) vend = 0;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (motor_on) found = 1;
      end
      checkb("motor start", found, 1'b1);
      for (int unsigned k = 1; k <= TO; k++) begin
         @(negedge clk);
         if (k == TO - 1) begin
            checkb("pre-timeout fault", fault, 1'b0);
            checkb("pre-timeout motor", motor_on, 1'b1);
         end
      end
      checkb("timeout fault", fault, 1'b1);
      checkb("motor off in fault", motor_on, 1'b0);
      vend = 1;
      @(negedge clk) vend = 0;
      repeat (3) @(negedge clk);
      checkb("fault holds", fault, 1'b1);
      checkb("busy in fault", busy, 1'b1);
      clr_fault = 1;
      @(negedge clk) clr_fault = 0;
      checkb("clear fault", fault, 1'b0);
      checkb("idle after clear", motor_on, 1'b0);
      @(negedge clk) checkb("retry motor", motor_on, 1'b1);
      product_sensed = 1;
      @(negedge clk) product_sensed = 0;
      checkb("motor drop", motor_on, 1'b0);
      @(negedge clk) checkb("second motor", motor_on, 1'b1);
      product_sensed = 1;
      @(negedge clk) product_sensed = 0;
      checkb("fault queue drained", busy, 1'b0);

      // Eight back-to-back vends saturate the product queue at seven
      do_reset(1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 7) checkb("overflow before 8th", overflow, 1'b0);
         vend = 1;
      end
      @(negedge clk) vend = 0;
      checkb("overflow after 8th", overflow, 1'b1);
      ops = 0; cyc = 0;
      while (busy && cyc < 300) begin
         @(negedge clk);
         cyc++;
         product_sensed = motor_on;
         if (motor_on) ops++;
      end
      product_sensed = 0;
      checkn("saturated motor ops", ops, SAT);
      checkb("overflow sticky", overflow, 1'b1);
      checkb("saturation drained", busy, 1'b0);

      // Reset while the 10$ hopper is ejecting
      do_reset(1'b0);
      @(negedge clk) change = 2'b10;
      @(negedge clk) change = 2'b00;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (eject10) found = 1;
      end
      checkb("eject10 start", found, 1'b1);
      #2 rst = 1;
      #1;
      checkb("eject10 async drop", eject10, 1'b0);
      checkb("busy async drop", busy, 1'b0);
      @(negedge clk) rst = 0;
      repeat (5) @(negedge clk);
      checkn("queue lost after reset", {motor_on, eject5, eject10, busy, overflow}, 0);

      random_phase(1'b0, 600);
      random_phase(1'b1, 600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
